// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the alu sequencer: FSM states, alu function-select codes,
// and the flag-vector packing used by both the sequencer and the alu control decoder.
package alu_sequencer_pkg;

   localparam int DW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_t;

   localparam logic [2:0] FS_ADD = 3'b000;
   localparam logic [2:0] FS_SUB = 3'b001;

   function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                             input logic n, input logic z);
      return {c, v, n, z};
   endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file for the alu sequencer: NREGS x 4 bits, two asynchronous read ports,
// one synchronous write port, cleared by synchronous reset.
module seq_regfile
   import alu_sequencer_pkg::*;
#(
   parameter int NREGS = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] i_raddr_a,
   output logic [DW-1:0] o_rdata_a,
   input  logic [AW-1:0] i_raddr_b,
   output logic [DW-1:0] o_rdata_b,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata
);

   logic [DW-1:0] r_regs [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_regs[i_raddr_a];
   assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven front end for the 4-bit alu: reads operands from the register file,
// drives registered A/B/FS to the alu, writes Y back and returns a response with flags.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int NREGS = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_load,
   input  logic [2:0]    cmd_fs,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_ra,
   input  logic [AW-1:0] cmd_rb,
   input  logic [3:0]    cmd_imm,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [3:0]    rsp_data,
   output logic [3:0]    rsp_flags,
   output logic [3:0]    alu_a,
   output logic [3:0]    alu_b,
   output logic [2:0]    alu_fs,
   input  logic [3:0]    alu_y,
   input  logic          alu_c,
   input  logic          alu_v,
   input  logic          alu_n,
   input  logic          alu_z,
   output logic [3:0]    flags
);

   seq_state_t    r_state;
   seq_state_t    w_next;
   logic [AW-1:0] r_rd;
   logic [3:0]    r_alu_a;
   logic [3:0]    r_alu_b;
   logic [2:0]    r_alu_fs;
   logic [3:0]    r_rsp_data;
   logic [3:0]    r_rsp_flags;
   logic [3:0]    r_flags;

   logic          w_accept;
   logic          w_cmd_ready;
   logic          w_rsp_valid;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [3:0]    w_wdata;
   logic [3:0]    w_rdata_a;
   logic [3:0]    w_rdata_b;
   logic [3:0]    w_alu_flags;

   seq_regfile #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .i_raddr_a (cmd_ra),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (cmd_rb),
      .o_rdata_b (w_rdata_b),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata)
   );

   assign w_alu_flags = pack_flags(alu_c, alu_v, alu_n, alu_z);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Loads write the register file at the accept edge; alu ops write at the close of EXEC.
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_cmd_ready = 1'b0;
      w_rsp_valid = 1'b0;
      w_we        = 1'b0;
      w_waddr     = r_rd;
      w_wdata     = alu_y;
      case (r_state)
         ST_IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_accept = 1'b1;
               if (cmd_load) begin
                  w_we    = 1'b1;
                  w_waddr = cmd_rd;
                  w_wdata = cmd_imm;
                  w_next  = ST_RESP;
               end else begin
                  w_next = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            w_we   = 1'b1;
            w_next = ST_RESP;
         end
         ST_RESP: begin
            w_rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd        <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_fs    <= '0;
         r_rsp_data  <= '0;
         r_rsp_flags <= '0;
         r_flags     <= '0;
      end else begin
         if (w_accept && cmd_load) begin
            r_rsp_data  <= cmd_imm;
            r_rsp_flags <= '0;
         end else if (w_accept) begin
            // Operands sampled here, so rd aliasing ra/rb sees the pre-op value.
            r_alu_a  <= w_rdata_a;
            r_alu_b  <= w_rdata_b;
            r_alu_fs <= cmd_fs;
            r_rd     <= cmd_rd;
         end
         if (r_state == ST_EXEC) begin
            r_rsp_data  <= alu_y;
            r_rsp_flags <= w_alu_flags;
            r_flags     <= w_alu_flags;
         end
      end
   end

   assign cmd_ready = w_cmd_ready;
   assign rsp_valid = w_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_flags = r_rsp_flags;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_fs    = r_alu_fs;
   assign flags     = r_flags;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural 4-bit alu attached and a
// register-file/flags reference model computed from plain arithmetic.
module tb_alu_sequencer;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_load;
   logic [2:0] cmd_fs;
   logic [1:0] cmd_rd;
   logic [1:0] cmd_ra;
   logic [1:0] cmd_rb;
   logic [3:0] cmd_imm;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic [3:0] rsp_flags;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_fs;
   logic [3:0] alu_y;
   logic       alu_c;
   logic       alu_v;
   logic       alu_n;
   logic       alu_z;
   logic [3:0] flags;

   int checks = 0;
   int errors = 0;

   logic [3:0] ref_regs [4];
   logic [3:0] ref_flags;

   alu_sequencer #(.NREGS(4), .AW(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_load  (cmd_load),
      .cmd_fs    (cmd_fs),
      .cmd_rd    (cmd_rd),
      .cmd_ra    (cmd_ra),
      .cmd_rb    (cmd_rb),
      .cmd_imm   (cmd_imm),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_flags (rsp_flags),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_fs    (alu_fs),
      .alu_y     (alu_y),
      .alu_c     (alu_c),
      .alu_v     (alu_v),
      .alu_n     (alu_n),
      .alu_z     (alu_z),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {Y, C, V, N, Z}; C on subtract means "no borrow".
   function automatic logic [7:0] alu_eval(input logic [2:0] fs, input logic [3:0] a,
                                           input logic [3:0] b);
      int sa, sb, r;
      logic [3:0] y;
      logic c, v;
      sa = a[3] ? int'(a) - 16 : int'(a);
      sb = b[3] ? int'(b) - 16 : int'(b);
      c = 1'b0;
      v = 1'b0;
      y = 4'd0;
      case (fs)
         3'd0: begin
            r = int'(a) + int'(b);
            y = r[3:0];
            c = (r > 15);
            r = sa + sb;
            v = (r > 7) || (r < -8);
         end
         3'd1: begin
            r = int'(a) - int'(b);
            y = r[3:0];
            c = (a >= b);
            r = sa - sb;
            v = (r > 7) || (r < -8);
         end
         3'd2: y = a & b;
         3'd3: y = a | b;
         3'd4: y = a ^ b;
         3'd5: y = ~a;
         3'd6: y = a;
         default: y = b;
      endcase
      return {y, c, v, y[3], (y == 4'd0)};
   endfunction

   assign {alu_y, alu_c, alu_v, alu_n, alu_z} = alu_eval(alu_fs, alu_a, alu_b);

   task automatic model_reset();
      for (int i = 0; i < 4; i++) ref_regs[i] = 4'd0;
      ref_flags = 4'd0;
   endtask

   task automatic model_cmd(input logic ld, input logic [2:0] fs, input logic [1:0] rd,
                            input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] imm,
                            output logic [3:0] ed, output logic [3:0] ef);
      logic [7:0] res;
      if (ld) begin
         ed = imm;
         ef = 4'd0;
      end else begin
         res = alu_eval(fs, ref_regs[ra], ref_regs[rb]);
         ed = res[7:4];
         ef = res[3:0];
         ref_flags = ef;
      end
      ref_regs[rd] = ed;
   endtask

   // Issues one command and waits for its response; leaves the response pending.
   task automatic do_cmd(input logic ld, input logic [2:0] fs, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] imm,
                         output logic [3:0] d, output logic [3:0] f, output int lat);
      int n;
      n = 0;
      cmd_load = ld; cmd_fs = fs; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
      cmd_valid = 1'b1;
      d = 4'd0;
      f = 4'd0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         lat = -1;
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) lat = -1;
      d = rsp_data;
      f = rsp_flags;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      checks++;
      if ({rsp_valid, rsp_data, rsp_flags, flags, alu_a, alu_b, alu_fs} !== 24'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {rsp_valid, rsp_data, rsp_flags, flags, alu_a, alu_b, alu_fs});
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_load();
      logic [3:0] d, f, ed, ef;
      int lat;
      logic [3:0] vals [2];
      vals[0] = 4'd7;
      vals[1] = 4'd9;
      for (int i = 0; i < 2; i++) begin
         model_cmd(1'b1, 3'd0, 2'(i), 2'd0, 2'd0, vals[i], ed, ef);
         do_cmd(1'b1, 3'd0, 2'(i), 2'd0, 2'd0, vals[i], d, f, lat);
         checks++;
         if (lat !== 1 || d !== ed || f !== ef) begin
            errors++;
            $display("FAIL load_R%0d got lat=%0d data=%h flags=%b want lat=1 data=%h flags=%b",
                     i, lat, d, f, ed, ef);
         end
         finish_rsp();
      end
   endtask

   task automatic test_add_carry();
      logic [3:0] d, f, ed, ef;
      int lat;
      model_cmd(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 4'd0, ed, ef);
      do_cmd(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 4'd0, d, f, lat);
      checks++;
      if (lat !== 2 || d !== 4'h0 || f !== 4'b1001) begin
         errors++;
         $display("FAIL add_7_9 got lat=%0d data=%h flags=%b want lat=2 data=0 flags=1001",
                  lat, d, f);
      end
      checks++;
      if (flags !== 4'b1001 || ed !== 4'h0 || ef !== 4'b1001) begin
         errors++;
         $display("FAIL add_sticky_flags got %b model %h/%b want 1001", flags, ed, ef);
      end
      finish_rsp();
      // R2 must now hold 0: R2 | R0 returns R0 exactly.
      model_cmd(1'b0, 3'd3, 2'd3, 2'd2, 2'd0, 4'd0, ed, ef);
      do_cmd(1'b0, 3'd3, 2'd3, 2'd2, 2'd0, 4'd0, d, f, lat);
      checks++;
      if (lat !== 2 || d !== ed || f !== ef) begin
         errors++;
         $display("FAIL add_writeback got data=%h flags=%b want data=%h flags=%b", d, f, ed, ef);
      end
      finish_rsp();
   endtask

   task automatic test_sub_hold();
      logic [3:0] d, f, ed, ef;
      int lat;
      model_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd3, ed, ef);
      do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd3, d, f, lat);
      finish_rsp();
      model_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5, ed, ef);
      do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5, d, f, lat);
      finish_rsp();
      model_cmd(1'b0, 3'b001, 2'd3, 2'd0, 2'd1, 4'd0, ed, ef);
      do_cmd(1'b0, 3'b001, 2'd3, 2'd0, 2'd1, 4'd0, d, f, lat);
      checks++;
      if (lat !== 2 || d !== 4'hE || f[3] !== 1'b0 || f[0] !== 1'b0 || f !== ef) begin
         errors++;
         $display("FAIL sub_3_5 got lat=%0d data=%h flags=%b want lat=2 data=e flags=%b",
                  lat, d, f, ef);
      end
      finish_rsp();
      model_cmd(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'hE, ed, ef);
      do_cmd(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'hE, d, f, lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({rsp_valid, cmd_ready, rsp_data, rsp_flags} !== {1'b1, 1'b0, ed, ef}) begin
            errors++;
            $display("FAIL hold_cycle%0d got v=%b rdy=%b data=%h flags=%b want v=1 rdy=0 data=%h flags=%b",
                     i, rsp_valid, cmd_ready, rsp_data, rsp_flags, ed, ef);
         end
      end
      finish_rsp();
   endtask

   task automatic test_alias_overflow();
      logic [3:0] d, f, ed, ef;
      int lat;
      model_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd6, ed, ef);
      do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd6, d, f, lat);
      finish_rsp();
      model_cmd(1'b0, 3'b000, 2'd1, 2'd1, 2'd1, 4'd0, ed, ef);
      do_cmd(1'b0, 3'b000, 2'd1, 2'd1, 2'd1, 4'd0, d, f, lat);
      checks++;
      if (d !== 4'hC || f !== 4'b0110 || f !== ef) begin
         errors++;
         $display("FAIL alias_6p6 got data=%h flags=%b want data=c flags=0110", d, f);
      end
      finish_rsp();
      model_cmd(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd1, ed, ef);
      do_cmd(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd1, d, f, lat);
      checks++;
      if (flags !== 4'b0110 || f !== 4'b0000) begin
         errors++;
         $display("FAIL load_keeps_flags got flags=%b rsp_flags=%b want 0110/0000", flags, f);
      end
      finish_rsp();
      // C + C = 8 with carry; confirms R1 really holds C.
      model_cmd(1'b0, 3'b000, 2'd0, 2'd1, 2'd1, 4'd0, ed, ef);
      do_cmd(1'b0, 3'b000, 2'd0, 2'd1, 2'd1, 4'd0, d, f, lat);
      checks++;
      if (d !== ed || f !== ef) begin
         errors++;
         $display("FAIL alias_readback got data=%h flags=%b want data=%h flags=%b", d, f, ed, ef);
      end
      finish_rsp();
   endtask

   task automatic test_reset_exec();
      logic [3:0] d, f, ed, ef;
      int lat;
      model_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd2, ed, ef);
      do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd2, d, f, lat);
      finish_rsp();
      model_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3, ed, ef);
      do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3, d, f, lat);
      finish_rsp();
      cmd_load = 1'b0; cmd_fs = 3'b000; cmd_rd = 2'd2; cmd_ra = 2'd0; cmd_rb = 2'd1;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || flags !== 4'd0) begin
         errors++;
         $display("FAIL reset_in_exec got v=%b rdy=%b flags=%b want v=0 rdy=1 flags=0000",
                  rsp_valid, cmd_ready, flags);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_rsp cycle%0d got v=%b want 0", i, rsp_valid);
         end
      end
      model_cmd(1'b0, 3'b000, 2'd3, 2'd2, 2'd2, 4'd0, ed, ef);
      do_cmd(1'b0, 3'b000, 2'd3, 2'd2, 2'd2, 4'd0, d, f, lat);
      checks++;
      if (lat !== 2 || d !== ed || f !== ef) begin
         errors++;
         $display("FAIL r2_after_reset got data=%h flags=%b want data=%h flags=%b", d, f, ed, ef);
      end
      finish_rsp();
   endtask

   task automatic test_back_to_back();
      localparam int N = 8;
      logic [2:0] q_fs [N];
      logic [1:0] q_rd [N];
      logic [1:0] q_ra [N];
      logic [1:0] q_rb [N];
      logic [3:0] q_ed [N];
      logic [3:0] q_ef [N];
      int idx, nresp, cyc, last_acc;
      logic acc_now;
      for (int i = 0; i < N; i++) begin
         q_fs[i] = 3'($urandom_range(0, 7));
         q_rd[i] = 2'($urandom_range(0, 3));
         q_ra[i] = 2'($urandom_range(0, 3));
         q_rb[i] = 2'($urandom_range(0, 3));
         model_cmd(1'b0, q_fs[i], q_rd[i], q_ra[i], q_rb[i], 4'd0, q_ed[i], q_ef[i]);
      end
      idx = 0; nresp = 0; cyc = 0; last_acc = -1;
      rsp_ready = 1'b1;
      cmd_load = 1'b0; cmd_fs = q_fs[0]; cmd_rd = q_rd[0]; cmd_ra = q_ra[0]; cmd_rb = q_rb[0];
      cmd_valid = 1'b1;
      while ((idx < N || nresp < N) && cyc < 200) begin
         if (rsp_valid) begin
            checks++;
            if (nresp >= N || rsp_data !== q_ed[nresp] || rsp_flags !== q_ef[nresp]) begin
               errors++;
               $display("FAIL b2b_rsp%0d got data=%h flags=%b want data=%h flags=%b", nresp,
                        rsp_data, rsp_flags, q_ed[nresp % N], q_ef[nresp % N]);
            end
            nresp++;
         end
         acc_now = cmd_ready && cmd_valid;
         if (acc_now) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc !== 3) begin
                  errors++;
                  $display("FAIL b2b_interval%0d got %0d want 3", idx, cyc - last_acc);
               end
            end
            last_acc = cyc;
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            if (idx < N) begin
               cmd_fs = q_fs[idx]; cmd_rd = q_rd[idx]; cmd_ra = q_ra[idx]; cmd_rb = q_rb[idx];
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      checks++;
      if (idx !== N || nresp !== N) begin
         errors++;
         $display("FAIL b2b_counts got accepts=%0d responses=%0d want %0d", idx, nresp, N);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [3:0] d, f, ed, ef, imm;
      logic ld;
      logic [2:0] fs;
      logic [1:0] rd, ra, rb;
      int lat;
      for (int i = 0; i < 30; i++) begin
         ld  = ($urandom_range(0, 3) == 0);
         fs  = 3'($urandom_range(0, 7));
         rd  = 2'($urandom_range(0, 3));
         ra  = 2'($urandom_range(0, 3));
         rb  = 2'($urandom_range(0, 3));
         imm = 4'($urandom_range(0, 15));
         model_cmd(ld, fs, rd, ra, rb, imm, ed, ef);
         do_cmd(ld, fs, rd, ra, rb, imm, d, f, lat);
         checks++;
         if (lat !== (ld ? 1 : 2) || d !== ed || f !== ef || flags !== ref_flags) begin
            errors++;
            $display("FAIL rand%0d ld=%b fs=%0d got lat=%0d data=%h flags=%b sticky=%b want lat=%0d data=%h flags=%b sticky=%b",
                     i, ld, fs, lat, d, f, flags, ld ? 1 : 2, ed, ef, ref_flags);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         finish_rsp();
      end
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_load = 1'b0;
      cmd_fs = 3'd0;
      cmd_rd = 2'd0;
      cmd_ra = 2'd0;
      cmd_rb = 2'd0;
      cmd_imm = 4'd0;
      rsp_ready = 1'b0;
      test_reset();
      test_load();
      test_add_carry();
      test_sub_hold();
      test_alias_overflow();
      test_reset_exec();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
